// File: rtl/mips32_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : mips32_prefetch_queue
// Purpose  : MIPS32 instruction prefetch queue. Fetches words over a req/ack
//            handshake, buffers {IR, NPC} pairs, flushes on branch redirect.
// Options  : PFQ_HALT_STOP_EN - stop fetching after an HLT (opcode 6'b111111)
//            word is enqueued, until the next redirect or reset.
// Revision : 1.0 - initial release
// ============================================================================
module mips32_prefetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   output logic [31:0]       out_ir,
   output logic [31:0]       out_npc,
   input  logic              out_ready,
   output logic [31:0]       debug_pc
);

   localparam int               c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

   logic              r_req;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic              r_discard;
   logic [c_ptr_w:0]  r_rd_ptr;
   logic [c_ptr_w:0]  r_wr_ptr;
   logic [c_ptr_w:0]  r_count;
   logic [31:0]       r_ir  [DEPTH];
   logic [31:0]       r_npc [DEPTH];

   logic              w_ack;
   logic              w_enq;
   logic              w_deq;
   logic              w_pending_next;
   logic              w_issue;
   logic              w_halt_block;
   logic [c_ptr_w:0]  w_count_next;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] w_addr_inc;
   logic [31:0]       w_npc;

   assign w_ack      = r_req & imem_ack;
   assign w_deq      = (r_count != '0) & out_ready & ~redirect;
   assign w_addr_inc = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
   // NPC is formed at 32 bits so the last memory word yields 2^ADDR_W
   assign w_npc      = {{(32-ADDR_W){1'b0}}, r_addr} + 32'd1;

`ifdef PFQ_HALT_STOP_EN
   localparam logic [5:0] c_hlt_op = 6'b111111;
   logic r_halted;
   logic w_hlt_seen;

   assign w_enq        = w_ack & ~r_discard & ~redirect & ~r_halted;
   assign w_hlt_seen   = w_enq & (imem_rdata[31:26] == c_hlt_op);
   assign w_halt_block = ~redirect & (r_halted | w_hlt_seen);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted <= 1'b0;
      end else if (redirect) begin
         r_halted <= 1'b0;
      end else if (w_hlt_seen) begin
         r_halted <= 1'b1;
      end
   end
`else
   assign w_enq        = w_ack & ~r_discard & ~redirect;
   assign w_halt_block = 1'b0;
`endif

   always_comb begin
      w_count_next   = r_count;
      w_pc_next      = r_fetch_pc;
      w_pending_next = r_req & ~imem_ack;
      if (redirect) begin
         w_count_next = '0;
         w_pc_next    = redirect_pc;
      end else begin
         w_count_next = r_count + {{c_ptr_w{1'b0}}, w_enq} - {{c_ptr_w{1'b0}}, w_deq};
         if (w_enq) begin
            w_pc_next = w_addr_inc;
         end
      end
      // a discarded ack leaves one idle cycle before the refetch goes out
      w_issue = ~w_pending_next & ~(w_ack & r_discard) &
                (w_count_next < c_depth) & ~w_halt_block;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req      <= 1'b0;
         r_addr     <= '0;
         r_fetch_pc <= '0;
         r_discard  <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ir[i]  <= '0;
            r_npc[i] <= '0;
         end
      end else begin
         r_req      <= w_pending_next | w_issue;
         r_fetch_pc <= w_pc_next;
         r_count    <= w_count_next;
         if (w_issue) begin
            r_addr <= w_pc_next;
         end
         if (redirect && w_pending_next) begin
            r_discard <= 1'b1;
         end else if (w_ack) begin
            r_discard <= 1'b0;
         end
         if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_enq) begin
               r_ir[r_wr_ptr[c_ptr_w-1:0]]  <= imem_rdata;
               r_npc[r_wr_ptr[c_ptr_w-1:0]] <= w_npc;
               r_wr_ptr                     <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_addr;
   assign out_valid = (r_count != '0);
   assign out_ir    = r_ir[r_rd_ptr[c_ptr_w-1:0]];
   assign out_npc   = r_npc[r_rd_ptr[c_ptr_w-1:0]];
   assign debug_pc  = {{(32-ADDR_W){1'b0}}, r_fetch_pc};

endmodule
`default_nettype wire

// File: tb/tb_mips32_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_prefetch_queue
// Purpose  : Self-checking bench for mips32_prefetch_queue (table vectors plus
//            directed redirect, wrap, halt and mid-operation reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips32_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance, ADDR_W = 10
   logic        req, ack, redirect, valid, ready;
   logic [9:0]  addr, rpc;
   logic [31:0] rdata, ir, npc, dbg;
   logic [3:0]  wait_cnt;
   logic [3:0]  ack_delay = 4'd0;
   logic        halt_mode = 1'b0;

   // narrow instance for address wrap, ADDR_W = 4, zero-wait memory
   logic        req4, redir4, valid4, ready4;
   logic [3:0]  addr4, rpc4;
   logic [31:0] ir4, npc4, dbg4, rdata4;

   assign rdata  = (halt_mode && addr == 10'd2) ? 32'hFC00_0000 : 32'h100 + {22'b0, addr};
   assign ack    = req && (wait_cnt == ack_delay);
   assign rdata4 = 32'h100 + {28'b0, addr4};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)           wait_cnt <= '0;
      else if (!req || ack) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + 4'd1;
   end

   mips32_prefetch_queue #(.DEPTH(4), .ADDR_W(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
      .imem_rdata(rdata), .redirect(redirect), .redirect_pc(rpc), .out_valid(valid),
      .out_ir(ir), .out_npc(npc), .out_ready(ready), .debug_pc(dbg));

   mips32_prefetch_queue #(.DEPTH(4), .ADDR_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .imem_req(req4), .imem_addr(addr4), .imem_ack(req4),
      .imem_rdata(rdata4), .redirect(redir4), .redirect_pc(rpc4), .out_valid(valid4),
      .out_ir(ir4), .out_npc(npc4), .out_ready(ready4), .debug_pc(dbg4));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      redirect = 1'b0;
      rpc      = '0;
      ready    = 1'b0;
      redir4   = 1'b0;
      rpc4     = '0;
      ready4   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        rdy;
      logic        rd;
      logic [9:0]  rpc;
      logic        e_req;
      logic [9:0]  e_addr;
      logic        e_valid;
      logic [31:0] e_ir;
      logic [31:0] e_npc;
      logic [31:0] e_dbg;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic       found;
      logic [9:0] max_addr;
      logic [9:0] new_addr;
      logic       new_seen;
      logic       saw_hlt;

      // fill with out_ready=0, then stream, then a redirect with coincident ack
      vecs[0]  = '{1'b0, 1'b0, 10'h0,  1'b1, 10'd0,  1'b0, 32'h0,   32'd0,  32'd0};
      vecs[1]  = '{1'b0, 1'b0, 10'h0,  1'b1, 10'd1,  1'b1, 32'h100, 32'd1,  32'd1};
      vecs[2]  = '{1'b0, 1'b0, 10'h0,  1'b1, 10'd2,  1'b1, 32'h100, 32'd1,  32'd2};
      vecs[3]  = '{1'b0, 1'b0, 10'h0,  1'b1, 10'd3,  1'b1, 32'h100, 32'd1,  32'd3};
      vecs[4]  = '{1'b0, 1'b0, 10'h0,  1'b0, 10'd3,  1'b1, 32'h100, 32'd1,  32'd4};
      vecs[5]  = '{1'b0, 1'b0, 10'h0,  1'b0, 10'd3,  1'b1, 32'h100, 32'd1,  32'd4};
      vecs[6]  = '{1'b1, 1'b0, 10'h0,  1'b1, 10'd4,  1'b1, 32'h101, 32'd2,  32'd4};
      vecs[7]  = '{1'b1, 1'b0, 10'h0,  1'b1, 10'd5,  1'b1, 32'h102, 32'd3,  32'd5};
      vecs[8]  = '{1'b1, 1'b0, 10'h0,  1'b1, 10'd6,  1'b1, 32'h103, 32'd4,  32'd6};
      vecs[9]  = '{1'b1, 1'b1, 10'h30, 1'b1, 10'h30, 1'b0, 32'h0,   32'd0,  32'h30};
      vecs[10] = '{1'b0, 1'b0, 10'h0,  1'b1, 10'h31, 1'b1, 32'h130, 32'h31, 32'h31};
      vecs[11] = '{1'b1, 1'b0, 10'h0,  1'b1, 10'h32, 1'b1, 32'h131, 32'h32, 32'h32};

      do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_req",   {31'b0, req},   32'd0);
      chk("rst_addr",  {22'b0, addr},  32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_ir",    ir,             32'd0);
      chk("rst_npc",   npc,            32'd0);
      chk("rst_dbg",   dbg,            32'd0);
      do_reset();

      for (int i = 0; i < 12; i++) begin
         ready    = vecs[i].rdy;
         redirect = vecs[i].rd;
         rpc      = vecs[i].rpc;
         tick();
         redirect = 1'b0;
         chk($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vecs[i].e_req});
         if (vecs[i].e_req)
            chk($sformatf("v%0d_addr", i), {22'b0, addr}, {22'b0, vecs[i].e_addr});
         chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d_ir", i),  ir,  vecs[i].e_ir);
            chk($sformatf("v%0d_npc", i), npc, vecs[i].e_npc);
         end
         chk($sformatf("v%0d_dbg", i), dbg, vecs[i].e_dbg);
      end

      // address wrap on the narrow instance
      ready4 = 1'b0;
      redir4 = 1'b1;
      rpc4   = 4'd15;
      tick();
      redir4 = 1'b0;
      chk("wrap_req15",  {31'b0, req4},  32'd1);
      chk("wrap_addr15", {28'b0, addr4}, 32'd15);
      tick();
      chk("wrap_addr0",  {28'b0, addr4}, 32'd0);
      chk("wrap_valid",  {31'b0, valid4}, 32'd1);
      chk("wrap_npc_hi", npc4, 32'h10);
      chk("wrap_ir_hi",  ir4,  32'h10F);
      ready4 = 1'b1;
      tick();
      chk("wrap_npc_lo", npc4, 32'h1);
      chk("wrap_ir_lo",  ir4,  32'h100);

      // late-ack redirect while address 5 is outstanding
      ack_delay = 4'd3;
      do_reset();
      ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         tick();
         if (req && addr == 10'd5) found = 1'b1;
      end
      chk("late_reach5", {31'b0, found}, 32'd1);
      redirect = 1'b1;
      rpc      = 10'h20;
      tick();
      redirect = 1'b0;
      chk("late_hold_req",  {31'b0, req},  32'd1);
      chk("late_hold_addr", {22'b0, addr}, 32'd5);
      found    = 1'b0;
      new_seen = 1'b0;
      new_addr = '0;
      for (int c = 0; c < 30 && !found; c++) begin
         tick();
         if (req && addr != 10'd5 && !new_seen) begin
            new_seen = 1'b1;
            new_addr = addr;
         end
         if (valid) found = 1'b1;
      end
      chk("late_head_seen", {31'b0, found}, 32'd1);
      chk("late_new_addr",  {22'b0, new_addr}, 32'h20);
      chk("late_head_ir",   ir,  32'h120);
      chk("late_head_npc",  npc, 32'h21);

      // mid-operation asynchronous reset
      do_reset();
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick();
         if (valid && req && addr == 10'd2) found = 1'b1;
      end
      chk("mid_reach", {31'b0, found}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_req",   {31'b0, req},   32'd0);
      chk("mid_addr",  {22'b0, addr},  32'd0);
      chk("mid_valid", {31'b0, valid}, 32'd0);
      chk("mid_ir",    ir,  32'd0);
      chk("mid_npc",   npc, 32'd0);
      chk("mid_dbg",   dbg, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("mid_restart_req",  {31'b0, req},  32'd1);
      chk("mid_restart_addr", {22'b0, addr}, 32'd0);

      // HLT word at address 2
      ack_delay = 4'd0;
      halt_mode = 1'b1;
      do_reset();
      ready    = 1'b1;
      max_addr = '0;
      saw_hlt  = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (req && addr > max_addr) max_addr = addr;
         if (valid && ir == 32'hFC00_0000) saw_hlt = 1'b1;
      end
      chk("halt_word_out", {31'b0, saw_hlt}, 32'd1);
`ifdef PFQ_HALT_STOP_EN
      chk("halt_max_addr", {22'b0, max_addr}, 32'd2);
      chk("halt_idle",     {31'b0, req},      32'd0);
      redirect = 1'b1;
      rpc      = 10'd0;
      tick();
      redirect = 1'b0;
      chk("halt_resume_req",  {31'b0, req},  32'd1);
      chk("halt_resume_addr", {22'b0, addr}, 32'd0);
`else
      chk("nohalt_max_addr", {22'b0, max_addr}, 32'd11);
      chk("nohalt_req",      {31'b0, req},      32'd1);
`endif
      halt_mode = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
